// File: rtl/alu_defs_pkg.sv
// Shared ALU control codes, control width and arbiter FSM encodings.
package alu_defs;

    localparam int unsigned CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Index width for an n-entry vector; at least one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_req_arbiter_rr.sv
// Round-robin picker: first set request searching from ptr upward, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]                      req,
    input  logic [alu_defs::idx_width(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]                      grant_oh,
    output logic [alu_defs::idx_width(NUM_REQ)-1:0] grant_idx
);
    import alu_defs::*;

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    // Walk candidates ptr, ptr+1, ... mod NUM_REQ and keep the first hit.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            idx = (sum >= NUM_REQ_W) ? IDX_W'(sum - NUM_REQ_W) : IDX_W'(sum);
            if (!found && req[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters with
// round-robin arbitration and valid/ready handshakes on request and response.
module alu_req_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CTRL_W  = alu_defs::CTRL_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*CTRL_W-1:0]   req_op,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]          resp_valid,
    input  logic [NUM_REQ-1:0]          resp_ready,
    output logic [DATA_W-1:0]           resp_result,
    output logic                        resp_zero,
    output logic [CTRL_W-1:0]           alu_ctrl,
    output logic [DATA_W-1:0]           alu_a,
    output logic [DATA_W-1:0]           alu_b,
    input  logic [DATA_W-1:0]           alu_result,
    input  logic                        alu_zero
);
    import alu_defs::*;

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   grant_q;
    logic [CTRL_W-1:0]  op_q;
    logic [DATA_W-1:0]  a_q, b_q;
    logic [DATA_W-1:0]  result_q;
    logic               zero_q;

    logic [NUM_REQ-1:0] grant_oh;
    logic [IDX_W-1:0]   grant_idx;

    logic [CTRL_W-1:0]  op_arr [NUM_REQ];
    logic [DATA_W-1:0]  a_arr  [NUM_REQ];
    logic [DATA_W-1:0]  b_arr  [NUM_REQ];

    for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
        assign op_arr[i] = req_op[i*CTRL_W +: CTRL_W];
        assign a_arr[i]  = req_a[i*DATA_W +: DATA_W];
        assign b_arr[i]  = req_b[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx)
    );

    // Next state and handshake decode; ready only ever asserted from IDLE.
    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        resp_valid = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready = grant_oh;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid[grant_q] = 1'b1;
                if (resp_ready[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand capture, result capture and pointer rotation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant_q <= grant_idx;
                        op_q    <= op_arr[grant_idx];
                        a_q     <= a_arr[grant_idx];
                        b_q     <= b_arr[grant_idx];
                    end
                end
                ST_EXEC: begin
                    result_q <= alu_result;
                    zero_q   <= alu_zero;
                end
                ST_RESP: begin
                    if (resp_ready[grant_q]) begin
                        rr_ptr_q <= (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_ctrl    = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign resp_result = result_q;
    assign resp_zero   = zero_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural ALU attached.
module tb_alu_req_arbiter;
    import alu_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_result;
    logic        resp_zero;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_req_arbiter #(.NUM_REQ(2), .DATA_W(32), .CTRL_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .alu_ctrl    (alu_ctrl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
    );

    // Reference ALU; undefined codes give 0.
    always_comb begin
        case (alu_ctrl)
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[idx*4 +: 4]  = op;
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
    endtask

    // One uncontended transaction from requester idx, checked end to end.
    task automatic do_req(input int idx, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic z,
                          input string tag);
        logic [1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        set_req(idx, op, a, b);
        req_valid = oh;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(oh));
        tick();
        req_valid = '0;
        #1;
        chk({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_exec_rvalid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_alu_ctrl"}, 32'(alu_ctrl), 32'(op));
        tick();
        chk({tag, "_rvalid"}, 32'(resp_valid), 32'(oh));
        chk({tag, "_result"}, resp_result, res);
        chk({tag, "_zero"}, 32'(resp_zero), 32'(z));
        resp_ready = oh;
        tick();
        resp_ready = '0;
        #1;
        chk({tag, "_rvalid_drop"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '0;
        tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rvalid", 32'(resp_valid), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_result", resp_result, 32'd0);
        reset = 1'b0;
        tick();

        // Single request, then subtract to zero on the other requester.
        do_req(0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, "add");
        do_req(1, ALU_SUB, 32'h1234, 32'h1234, 32'd0, 1'b1, "sub0");

        // Contention from reset: grants alternate r0, r1, r0, r1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        set_req(1, ALU_ADD, 32'd2, 32'd2);
        req_valid = 2'b11;
        #1;
        for (int n = 0; n < 4; n++) begin
            logic [1:0]  exp_oh;
            logic [31:0] exp_res;
            exp_oh  = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp_res = (n % 2 == 0) ? 32'd2 : 32'd4;
            chk("cont_ready", 32'(req_ready), 32'(exp_oh));
            tick();
            chk("cont_exec_ready", 32'(req_ready), 32'd0);
            tick();
            chk("cont_rvalid", 32'(resp_valid), 32'(exp_oh));
            chk("cont_result", resp_result, exp_res);
            resp_ready = 2'b11;
            tick();
            resp_ready = '0;
            #1;
        end
        req_valid = '0;
        #1;
        chk("cont_idle_rvalid", 32'(resp_valid), 32'd0);

        // Response backpressure with r1 waiting; r1 ready only after handshake.
        set_req(0, ALU_ADD, 32'd3, 32'd4);
        set_req(1, ALU_OR, 32'd8, 32'd1);
        req_valid = 2'b01;
        #1;
        chk("bp_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b10;
        tick();
        for (int n = 0; n < 5; n++) begin
            resp_ready = (n == 2) ? 2'b10 : 2'b00;
            #1;
            chk("bp_rvalid", 32'(resp_valid), 32'd1);
            chk("bp_result", resp_result, 32'd7);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 2'b01;
        tick();
        resp_ready = '0;
        #1;
        chk("bp_next_ready", 32'(req_ready), 32'd2);
        chk("bp_rvalid_drop", 32'(resp_valid), 32'd0);
        tick();
        req_valid = '0;
        tick();
        chk("bp_r1_result", resp_result, 32'd9);
        chk("bp_r1_rvalid", 32'(resp_valid), 32'd2);
        resp_ready = 2'b10;
        tick();
        resp_ready = '0;

        // Reset while in EXEC: operation dropped, pointer back to r0.
        set_req(1, ALU_OR, 32'hF0, 32'h0F);
        req_valid = 2'b10;
        #1;
        chk("rmid_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = '0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        chk("rmid_rvalid", 32'(resp_valid), 32'd0);
        chk("rmid_alu_a", alu_a, 32'd0);
        tick();
        chk("rmid_rvalid2", 32'(resp_valid), 32'd0);
        chk("rmid_result", resp_result, 32'd0);
        req_valid = 2'b11;
        #1;
        chk("rmid_ptr0", 32'(req_ready), 32'd1);
        req_valid = '0;
        #1;

        // Wraparound, undefined code, and the logic ops.
        do_req(0, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, "wrap");
        do_req(1, 4'b1111, 32'd5, 32'd6, 32'd0, 1'b1, "undef");
        do_req(0, ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, "and");
        do_req(1, ALU_OR, 32'hA000_0005, 32'h0500_0050, 32'hA500_0055, 1'b0, "or");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
